// File: rtl/pacman_pkg.sv
// Shared types and constants for the pacman game-state controller and collision_detect.
package pacman_pkg;

    typedef enum logic [2:0] {
        NONE   = 3'd0,
        WALL   = 3'd1,
        DOT    = 3'd2,
        PILL   = 3'd3,
        GHOST1 = 3'd4,
        GHOST2 = 3'd5
    } coll_t;

    typedef enum logic [2:0] {
        READY = 3'd0,
        PLAY  = 3'd1,
        DYING = 3'd2,
        OVER  = 3'd3,
        WON   = 3'd4
    } game_state_t;

    localparam int unsigned SCORE_W          = 16;
    localparam int unsigned LIVES_W          = 2;
    localparam int unsigned DOTS_W           = 8;
    localparam int unsigned PTS_DOT          = 10;
    localparam int unsigned PTS_PILL         = 50;
    localparam int unsigned PTS_GHOST_BASE   = 200;
    localparam int unsigned EXTRA_LIFE_SCORE = 10000;

    // Score addition clamped at all-ones.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter advanced by a step enable, with a registered zero flag.
module step_timer #(
    parameter int unsigned W = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q, count_d;
    logic         zero_q;

    // Clear beats load beats decrement; the count parks at zero.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            zero_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            zero_q  <= (count_d == '0);
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/pacman_game_ctrl.sv
// Per-step game-state controller: score, lives, dots, frightened timer, death freeze, win/over.
// Optional bonus life at 10000 points is built only when EXTRA_LIFE_EN is defined.
module pacman_game_ctrl
    import pacman_pkg::*;
#(
    parameter int unsigned TOTAL_DOTS        = 244,
    parameter int unsigned START_LIVES       = 3,
    parameter int unsigned POWER_STEPS       = 360,
    parameter int unsigned DEATH_STEPS       = 120,
    parameter int unsigned DOT_POINTS        = PTS_DOT,
    parameter int unsigned PILL_POINTS       = PTS_PILL,
    parameter int unsigned GHOST_BASE_POINTS = PTS_GHOST_BASE
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               step,
    input  logic               start,
    input  logic [2:0]         collision_type,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives,
    output logic [DOTS_W-1:0]  dots_left,
    output logic               power_mode,
    output logic               freeze,
    output logic [1:0]         ghost_eaten,
    output logic               respawn,
    output logic               game_over,
    output logic               game_won
);

    localparam int unsigned PWR_W = $clog2(POWER_STEPS + 1);
    localparam int unsigned DIE_W = $clog2(DEATH_STEPS + 1);

    localparam logic [2:0] S_READY = 3'(READY);
    localparam logic [2:0] S_PLAY  = 3'(PLAY);
    localparam logic [2:0] S_DYING = 3'(DYING);
    localparam logic [2:0] S_OVER  = 3'(OVER);
    localparam logic [2:0] S_WON   = 3'(WON);

    logic [2:0]         state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [DOTS_W-1:0]  dots_q, dots_d;
    logic [1:0]         mult_q, mult_d;
    logic [1:0]         ghost_eaten_q, ghost_eaten_d;
    logic               respawn_q, respawn_d;
    logic               freeze_q, game_over_q, game_won_q;
    logic               pwr_clear, pwr_load, pwr_dec, pwr_zero;
    logic               die_load, die_dec, die_zero;
    logic               eat;
`ifdef EXTRA_LIFE_EN
    logic               bonus_q, bonus_d;
`endif

    step_timer #(.W(PWR_W)) u_power_timer (
        .clk_i      (CLOCK_50),
        .rst_i      (reset),
        .clear_i    (pwr_clear),
        .load_i     (pwr_load),
        .load_val_i (PWR_W'(POWER_STEPS)),
        .dec_i      (pwr_dec),
        .zero_o     (pwr_zero)
    );

    // Loaded one short so the step that finds it at zero is the last frozen step.
    step_timer #(.W(DIE_W)) u_death_timer (
        .clk_i      (CLOCK_50),
        .rst_i      (reset),
        .clear_i    (1'b0),
        .load_i     (die_load),
        .load_val_i (DIE_W'(DEATH_STEPS - 1)),
        .dec_i      (die_dec),
        .zero_o     (die_zero)
    );

    always_comb begin
        state_d       = state_q;
        score_d       = score_q;
        lives_d       = lives_q;
        dots_d        = dots_q;
        mult_d        = mult_q;
        ghost_eaten_d = 2'b00;
        respawn_d     = 1'b0;
        pwr_clear     = 1'b0;
        pwr_load      = 1'b0;
        pwr_dec       = 1'b0;
        die_load      = 1'b0;
        die_dec       = 1'b0;
        eat           = 1'b0;
`ifdef EXTRA_LIFE_EN
        bonus_d       = bonus_q;
`endif
        case (state_q)
            S_READY: begin
                if (start) begin
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (step) begin
                    pwr_dec = 1'b1;
                    case (collision_type)
                        DOT: begin
                            if (dots_q != '0) begin
                                eat     = 1'b1;
                                score_d = sat_add(score_q, SCORE_W'(DOT_POINTS));
                                dots_d  = dots_q - DOTS_W'(1);
                            end
                        end
                        PILL: begin
                            if (dots_q != '0) begin
                                eat      = 1'b1;
                                score_d  = sat_add(score_q, SCORE_W'(PILL_POINTS));
                                dots_d   = dots_q - DOTS_W'(1);
                                pwr_load = 1'b1;
                                mult_d   = 2'd0;
                            end
                        end
                        GHOST1, GHOST2: begin
                            if (!pwr_zero) begin
                                score_d       = sat_add(score_q, SCORE_W'(GHOST_BASE_POINTS) << mult_q);
                                ghost_eaten_d = (collision_type == GHOST1) ? 2'b01 : 2'b10;
                                if (mult_q != 2'd3) begin
                                    mult_d = mult_q + 2'd1;
                                end
                            end else begin
                                lives_d   = lives_q - LIVES_W'(1);
                                pwr_clear = 1'b1;
                                die_load  = 1'b1;
                                state_d   = S_DYING;
                            end
                        end
                        default: ;
                    endcase
                    // Last dot ends the level on this same update.
                    if (eat && (dots_d == '0)) begin
                        pwr_clear = 1'b1;
                        state_d   = S_WON;
                    end
                end
            end
            S_DYING: begin
                if (step) begin
                    die_dec = 1'b1;
                    if (die_zero) begin
                        if (lives_q == '0) begin
                            state_d = S_OVER;
                        end else begin
                            respawn_d = 1'b1;
                            state_d   = S_PLAY;
                        end
                    end
                end
            end
            S_OVER, S_WON: begin
                if (start) begin
                    state_d   = S_READY;
                    score_d   = '0;
                    lives_d   = LIVES_W'(START_LIVES);
                    dots_d    = DOTS_W'(TOTAL_DOTS);
                    mult_d    = 2'd0;
                    respawn_d = 1'b1;
`ifdef EXTRA_LIFE_EN
                    bonus_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = S_READY;
            end
        endcase
`ifdef EXTRA_LIFE_EN
        // One bonus life per game on first reaching the threshold.
        if (!bonus_q && (score_d >= SCORE_W'(EXTRA_LIFE_SCORE))) begin
            bonus_d = 1'b1;
            if (lives_d != '1) begin
                lives_d = lives_d + LIVES_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q       <= S_READY;
            score_q       <= '0;
            lives_q       <= LIVES_W'(START_LIVES);
            dots_q        <= DOTS_W'(TOTAL_DOTS);
            mult_q        <= 2'd0;
            ghost_eaten_q <= 2'b00;
            respawn_q     <= 1'b0;
            freeze_q      <= 1'b1;
            game_over_q   <= 1'b0;
            game_won_q    <= 1'b0;
`ifdef EXTRA_LIFE_EN
            bonus_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            score_q       <= score_d;
            lives_q       <= lives_d;
            dots_q        <= dots_d;
            mult_q        <= mult_d;
            ghost_eaten_q <= ghost_eaten_d;
            respawn_q     <= respawn_d;
            freeze_q      <= (state_d != S_PLAY);
            game_over_q   <= (state_d == S_OVER);
            game_won_q    <= (state_d == S_WON);
`ifdef EXTRA_LIFE_EN
            bonus_q       <= bonus_d;
`endif
        end
    end

    assign score       = score_q;
    assign lives       = lives_q;
    assign dots_left   = dots_q;
    assign power_mode  = ~pwr_zero;
    assign freeze      = freeze_q;
    assign ghost_eaten = ghost_eaten_q;
    assign respawn     = respawn_q;
    assign game_over   = game_over_q;
    assign game_won    = game_won_q;

endmodule
